// File: rtl/rgb_pwm_if.sv
// Colour/control and PWM output bundle for the RGB LED driver.
// The master drives colour and control; the slave returns the PWM outputs.
interface rgb_pwm_if;
  logic [23:0] light;
  logic        load;
  logic        enable;
  logic        red_pwm;
  logic        green_pwm;
  logic        blue_pwm;
  logic        frame_start;

  modport master (
    output light, load, enable,
    input  red_pwm, green_pwm, blue_pwm, frame_start
  );

  modport slave (
    input  light, load, enable,
    output red_pwm, green_pwm, blue_pwm, frame_start
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM RGB driver with shadowed colour.
// Duty changes are held back until a period boundary.
module rgb_pwm_driver #(
  parameter int PRESCALE = 4
) (
  input logic      clk,
  input logic      rst_n,
  rgb_pwm_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [23:0]   shadow_q, shadow_d;
  logic [23:0]   active_q, active_d;
  logic          pend_q, pend_d;
  logic [2:0]    pwm_q, pwm_d;
  logic          fs_q, fs_d;
  logic          run;
  logic          tick;
  logic          wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      pwm_q    <= '0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pwm_q    <= pwm_d;
      fs_q     <= fs_d;
    end
  end

  always_comb begin
    state_d  = bus.enable ? RUN : IDLE;
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    run      = bus.enable && (state_q == RUN);
    tick     = (pre_q == PRE_LAST);
    wrap     = tick && (cnt_q == 8'hFF);

    if (run) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      cnt_d = tick ? cnt_q + 8'd1 : cnt_q;
      if (wrap && pend_q) begin
        active_d = shadow_q;
        pend_d   = 1'b0;
      end
      // A load on the wrap clock stays pending for the next boundary
      if (bus.load) begin
        shadow_d = bus.light;
        pend_d   = 1'b1;
      end
    end else begin
      pre_d = '0;
      cnt_d = '0;
      if (pend_q) begin
        active_d = shadow_q;
      end
      pend_d = 1'b0;
      if (bus.load) begin
        shadow_d = bus.light;
        active_d = bus.light;
      end
    end

    pwm_d = {3{run}} & {cnt_q < active_q[23:16],
                        cnt_q < active_q[15:8],
                        cnt_q < active_q[7:0]};
    fs_d  = run && (cnt_q == 8'd0) && (pre_q == '0);
  end

  assign bus.red_pwm     = pwm_q[2];
  assign bus.green_pwm   = pwm_q[1];
  assign bus.blue_pwm    = pwm_q[0];
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: per-period high-time scoreboard plus
// hand sequences for boundary, disable and async reset cases.
module tb_rgb_pwm_driver;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rgb_pwm_if ia ();
  rgb_pwm_if ib ();

  rgb_pwm_driver #(.PRESCALE(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  rgb_pwm_driver #(.PRESCALE(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  typedef struct {
    string nm;
    int    r;
    int    g;
    int    b;
    int    len;
  } exp_t;

  typedef struct {
    logic [23:0] light;
    int          r;
    int          g;
    int          b;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[5];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [3:0] samp(input int inst);
    if (inst == 0)
      return {ia.frame_start, ia.red_pwm, ia.green_pwm, ia.blue_pwm};
    return {ib.frame_start, ib.red_pwm, ib.green_pwm, ib.blue_pwm};
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic drive(input int inst, input logic en, input logic ld,
                       input logic [23:0] li);
    if (inst == 0) begin
      ia.enable = en;
      ia.load   = ld;
      ia.light  = li;
    end else begin
      ib.enable = en;
      ib.load   = ld;
      ib.light  = li;
    end
  endtask

  task automatic idle_load(input int inst, input logic [23:0] li);
    drive(inst, 1'b0, 1'b1, li);
    @(negedge clk);
    drive(inst, 1'b0, 1'b0, li);
    @(negedge clk);
  endtask

  task automatic push(input string nm, input int r, input int g,
                      input int b, input int len);
    exp_t e;
    e.nm  = nm;
    e.r   = r;
    e.g   = g;
    e.b   = b;
    e.len = len;
    sb.push_back(e);
  endtask

  task automatic wait_fs(input int inst);
    logic [3:0] s;
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      s = samp(inst);
      guard++;
    end while (!s[3] && guard < 3000);
    if (!s[3]) chk("wait_fs_timeout", 0, 1);
  endtask

  // Each period runs from one frame_start cycle up to the next one
  task automatic measure(input int inst, input int n);
    logic [3:0] s;
    logic [2:0] first;
    int guard;
    int cr, cg, cb, len;
    exp_t e;
    guard = 0;
    do begin
      @(negedge clk);
      s = samp(inst);
      guard++;
    end while (!s[3] && guard < 3000);
    if (!s[3]) begin
      chk("measure_fs_timeout", 0, 1);
      for (int k = 0; k < n; k++) void'(sb.pop_front());
      return;
    end
    for (int k = 0; k < n; k++) begin
      e = sb.pop_front();
      first = s[2:0];
      cr = 0;
      cg = 0;
      cb = 0;
      len = 0;
      do begin
        cr += int'(s[2]);
        cg += int'(s[1]);
        cb += int'(s[0]);
        len++;
        @(negedge clk);
        s = samp(inst);
      end while (!s[3] && len < 3000);
      chk({e.nm, "_red"}, cr, e.r);
      chk({e.nm, "_green"}, cg, e.g);
      chk({e.nm, "_blue"}, cb, e.b);
      chk({e.nm, "_len"}, len, e.len);
      chk({e.nm, "_red_at_fs"}, int'(first[2]), int'(e.r != 0));
    end
  endtask

  initial begin
    tbl[0] = '{24'h40_00_FF, 64, 0, 255};
    tbl[1] = '{24'h00_FF_01, 0, 255, 1};
    tbl[2] = '{24'h80_7F_02, 128, 127, 2};
    tbl[3] = '{24'hFF_FF_FF, 255, 255, 255};
    tbl[4] = '{24'h01_10_00, 1, 16, 0};

    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, 24'hFF_FFFF);
    drive(1, 1'b1, 1'b1, 24'hFF_FFFF);
    repeat (3) @(negedge clk);
    chk("rst_a_red", int'(ia.red_pwm), 0);
    chk("rst_a_green", int'(ia.green_pwm), 0);
    chk("rst_a_blue", int'(ia.blue_pwm), 0);
    chk("rst_a_fs", int'(ia.frame_start), 0);
    chk("rst_b_red", int'(ib.red_pwm), 0);
    chk("rst_b_green", int'(ib.green_pwm), 0);
    chk("rst_b_blue", int'(ib.blue_pwm), 0);
    chk("rst_b_fs", int'(ib.frame_start), 0);
    drive(0, 1'b1, 1'b0, 24'h0);
    drive(1, 1'b1, 1'b0, 24'h0);
    rst_n = 1'b1;
    push("post_rst_a", 0, 0, 0, 256);
    measure(0, 1);
    push("post_rst_b", 0, 0, 0, 1024);
    measure(1, 1);

    idle_load(0, 24'h40_00_FF);
    drive(0, 1'b1, 1'b0, 24'h40_00_FF);
    push("en_p1", 64, 0, 255, 256);
    push("en_p2", 64, 0, 255, 256);
    fork
      measure(0, 2);
      begin
        @(negedge clk);
        chk("en_fs_clk1", int'(ia.frame_start), 0);
        @(negedge clk);
        chk("en_fs_clk2", int'(ia.frame_start), 1);
      end
    join

    for (int i = 0; i < 5; i++) begin
      idle_load(0, tbl[i].light);
      drive(0, 1'b1, 1'b0, tbl[i].light);
      push($sformatf("tbl%0d_p1", i), tbl[i].r, tbl[i].g, tbl[i].b, 256);
      push($sformatf("tbl%0d_p2", i), tbl[i].r, tbl[i].g, tbl[i].b, 256);
      measure(0, 2);
    end

    idle_load(1, 24'h02_00_00);
    drive(1, 1'b1, 1'b0, 24'h02_00_00);
    push("pre4", 8, 0, 0, 1024);
    measure(1, 1);

    idle_load(0, 24'h10_00_00);
    drive(0, 1'b1, 1'b0, 24'h10_00_00);
    push("mid_cur", 16, 0, 0, 256);
    push("mid_next", 240, 0, 0, 256);
    fork
      measure(0, 2);
      begin
        wait_fs(0);
        repeat (100) @(negedge clk);
        drive(0, 1'b1, 1'b1, 24'hF0_00_00);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 24'hF0_00_00);
      end
    join

    push("wrap_cur", 240, 0, 0, 256);
    push("wrap_p1", 32, 0, 0, 256);
    push("wrap_p2", 128, 0, 0, 256);
    fork
      measure(0, 3);
      begin
        wait_fs(0);
        repeat (100) @(negedge clk);
        drive(0, 1'b1, 1'b1, 24'h20_00_00);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 24'h20_00_00);
        repeat (153) @(negedge clk);
        drive(0, 1'b1, 1'b1, 24'h80_00_00);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 24'h80_00_00);
      end
    join

    wait_fs(0);
    repeat (10) @(negedge clk);
    chk("dis_pre_red", int'(ia.red_pwm), 1);
    drive(0, 1'b1, 1'b1, 24'h33_00_00);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 24'h33_00_00);
    @(negedge clk);
    chk("dis_red", int'(ia.red_pwm), 0);
    chk("dis_fs", int'(ia.frame_start), 0);
    repeat (5) @(negedge clk);
    chk("dis_idle_red", int'(ia.red_pwm), 0);
    drive(0, 1'b1, 1'b0, 24'h33_00_00);
    push("reen", 51, 0, 0, 256);
    fork
      measure(0, 1);
      begin
        @(negedge clk);
        chk("reen_fs_clk1", int'(ia.frame_start), 0);
        @(negedge clk);
        chk("reen_fs_clk2", int'(ia.frame_start), 1);
      end
    join

    wait_fs(0);
    repeat (5) @(negedge clk);
    chk("ar_pre_red", int'(ia.red_pwm), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_a_red", int'(ia.red_pwm), 0);
    chk("ar_a_fs", int'(ia.frame_start), 0);
    chk("ar_b_red", int'(ib.red_pwm), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push("post_ar", 0, 0, 0, 256);
    measure(0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
